// File: rtl/serial_parity_pkg.sv
// Shared encodings for both ends of the serial parity link.
// FSM state codes and parity-mode constants.
package serial_parity_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial receive bus: bit stream in, recovered word out.
// master drives bits, slave is the checker.
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 4,
    parameter int ERR_W     = 8
);
    logic                 w;
    logic                 w_en;
    logic                 odd;
    logic                 clear;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_valid;
    logic                 parity_err;
    logic [ERR_W-1:0]     err_count;
    logic                 busy;

    modport master (
        output w, w_en, odd, clear,
        input  data_out, frame_valid, parity_err, err_count, busy
    );

    modport slave (
        input  w, w_en, odd, clear,
        output data_out, frame_valid, parity_err, err_count, busy
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones.
// clr is synchronous and wins over inc.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // count up until all-ones, then hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Receive-side parity checker: LSB-first data bits then parity.
// Emits the word with a one-cycle valid and counts bad frames.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS = 4,
    parameter int ERR_W     = 8
) (
    input logic clk,
    input logic reset,
    serial_parity_checker_if.slave bus
);

    localparam int CW = $clog2(DATA_BITS + 1);

    logic [1:0]           state;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;
    logic                 odd_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 err_now;
    logic                 err_inc;
    logic [ERR_W-1:0]     err_q;

    // parity bit check against the mode latched at frame start
    assign err_now = ((acc ^ bus.w) != odd_q);
    assign err_inc = bus.w_en & ~bus.clear
                   & (state == PARITY) & err_now;

    // frame FSM, deserialiser and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            odd_q   <= PAR_EVEN;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            if (bus.clear) begin
                state <= IDLE;
                count <= '0;
                acc   <= 1'b0;
            end else if (bus.w_en) begin
                case (state)
                    IDLE: begin
                        shreg[0] <= bus.w;
                        acc      <= bus.w;
                        odd_q    <= bus.odd;
                        count    <= CW'(1);
                        state    <= (DATA_BITS == 1) ? PARITY : DATA;
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (count == CW'(i)) begin
                                shreg[i] <= bus.w;
                            end
                        end
                        acc   <= acc ^ bus.w;
                        count <= count + CW'(1);
                        if (count == CW'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        data_q  <= shreg;
                        valid_q <= 1'b1;
                        perr_q  <= err_now;
                        count   <= '0;
                        acc     <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (bus.clear),
        .q     (err_q)
    );

    assign bus.data_out    = data_q;
    assign bus.frame_valid = valid_q;
    assign bus.parity_err  = perr_q;
    assign bus.err_count   = err_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side counterpart of the team's serial parity generator. Deserialises a framed serial bit stream (DATA_BITS data bits LSB-first, then one parity bit), checks parity in even or odd mode, presents the recovered word with a one-cycle valid pulse, and keeps a saturating error count. It sits at the receive end of the serial link, between the bit source and the consuming logic.

## Interface
- DATA_BITS, default 4: data bits per frame, at least 1.
- ERR_W, default 8: width of the error counter.
- clk  input  1: single clock; all state changes on the rising edge.
- reset  input  1: asynchronous, active-low reset (asserted when 0).
- w  input  1: serial bit, sampled only when w_en = 1.
- w_en  input  1: bit qualifier; one frame bit is consumed per cycle with w_en = 1.
- odd  input  1: parity mode; 0 = even, 1 = odd. Latched with the first data bit of each frame.
- clear  input  1: synchronous frame resync; drops any partial frame and zeroes err_count.
- data_out  output  DATA_BITS: last completed frame's data; bit 0 is the first bit received.
- frame_valid  output  1: one-cycle pulse when a frame completes.
- parity_err  output  1: qualified by frame_valid; 1 = parity mismatch.
- err_count  output  ERR_W: number of frames with a parity error, saturating.
- busy  output  1: 1 while a frame is partially received (state other than IDLE).

## Operation
- States:
  - IDLE: no frame in progress.
  - DATA: receiving data bits.
  - PARITY: waiting for the parity bit.
- IDLE with w_en = 1:
  - Shift w into bit 0 of the shift register.
  - Set the running XOR acc = w and latch odd.
  - Set bit count = 1.
  - Next state: DATA, or PARITY if DATA_BITS = 1.
- DATA with w_en = 1:
  - Shift w into position count, set acc ^= w, increment count.
  - When count reaches DATA_BITS, go to PARITY.
- PARITY with w_en = 1:
  - Error check: err = (acc ^ w) != latched odd.
  - Copy the shift register to data_out, pulse frame_valid, drive parity_err = err.
  - If err = 1, increment err_count.
  - Return to IDLE.
- w_en = 0 cycles: the FSM holds and no state changes. Gaps of any length inside a frame are legal.
- err_count saturates at 2^ERR_W − 1 and never wraps.
- clear = 1:
  - Next state is IDLE, count = 0, err_count = 0.
  - No frame_valid is produced, even if the same cycle carries a parity bit with w_en = 1.
  - data_out holds its value.
  - clear has priority over w_en.
- odd changes mid-frame have no effect on the current frame.
- Outputs between pulses:
  - data_out holds its value until the next frame_valid.
  - parity_err is 0 whenever frame_valid = 0.
- Reset values (reset = 0): state IDLE, count 0, acc 0, data_out 0, frame_valid 0, parity_err 0, err_count 0, busy 0. A reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- frame_valid, parity_err, data_out and the incremented err_count all appear in the cycle after the edge that samples the parity bit.
- Frame latency: DATA_BITS + 1 qualified bits, plus 1 cycle.
- Back-to-back frames need no idle cycle. A w_en in the cycle right after the parity bit starts the next frame while frame_valid is high.
- busy rises the cycle after the first data bit is sampled. It falls in the same cycle frame_valid rises.
- Reset asserts asynchronously. Deassertion must be synchronised externally to clk.

## Structure
- Shared package serial_parity_pkg, holding:
  - the state encoding: IDLE, DATA, PARITY as localparams/enum;
  - the parity-mode constants PAR_EVEN = 0, PAR_ODD = 1.
- The generator shares this package so both link ends agree on mode encoding.
- One sub-module: sat_counter (parameter WIDTH; ports inc, clr; saturating at all-ones; async active-low reset), used for err_count.
- Shift register, count and acc stay in the top module.

## Test plan
- Even frame, correct: DATA_BITS = 4, odd = 0, bits 1,0,1,1, parity 1 → data_out = 4'hD, frame_valid pulse, parity_err = 0, err_count = 0.
- Parity errors: same data, parity 0 → parity_err = 1, err_count = 1. Then odd = 1 with parity 0 → parity_err = 0, err_count stays 1.
- Gaps and back-to-back: w_en low 3 cycles between each bit of frame 0,0,0,1 / parity 1 (even), immediately followed by frame 1,1,1,1 / parity 0 → two pulses, data_out 4'h8 then 4'hF, no errors.
- clear mid-frame: send 2 bits, assert clear, then a full good frame → exactly one frame_valid, carrying the new frame's data; err_count = 0. Also: clear in the parity-bit cycle → no pulse.
- Reset mid-frame: reset = 0 after 3 bits → all outputs are 0 immediately (asynchronously). After release, a fresh frame decodes correctly.
- Saturation: ERR_W = 2, five bad frames → err_count goes 1, 2, 3, 3, 3.
